// File: rtl/bram_dual_arbiter_if.sv
// Client-side request/response bundle for bram_dual_arbiter.
// Client i owns bit i of every 2-bit vector and slice i of every packed bus.
interface bram_dual_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0]              req_we;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*DATA_WIDTH-1:0] req_data;
  logic [1:0]              rsp_valid;
  logic [1:0]              rsp_ready;
  logic [2*DATA_WIDTH-1:0] rsp_data;

  // Client side: issues requests, consumes responses.
  modport master (
    output req_valid, req_we, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  // Arbiter side: grants requests, produces responses.
  modport slave (
    input  req_valid, req_we, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/bram_dual_arbiter.sv
// Two-client arbiter in front of a simple dual-port RAM (one write port,
// one registered read port). Writes and reads are arbitrated independently
// with round-robin pointers; each client has a 2-entry read-response FIFO
// and reads are only granted when the response is guaranteed a FIFO slot.
module bram_dual_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  bram_dual_arbiter_if.slave    bus_if,
  output logic                  o_ram_we,
  output logic                  o_ram_re,
  output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
  output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
  output logic [DATA_WIDTH-1:0] o_ram_di,
  input  logic [DATA_WIDTH-1:0] i_ram_do
);

  // Per-client request fields unpacked from the packed buses.
  logic [ADDR_WIDTH-1:0] w_addr  [2];
  logic [DATA_WIDTH-1:0] w_wdata [2];

  // Arbitration.
  logic [1:0] w_wreq;
  logic [1:0] w_rreq;
  logic [1:0] w_wgnt;
  logic [1:0] w_rgnt;
  logic       w_wsel;
  logic       w_rsel;
  logic       w_wany;
  logic       w_rany;
  logic       w_collide;

  // Response path.
  logic [1:0] w_pop;
  logic [1:0] w_credit;

  // State.
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_inflight;
  logic [1:0]            r_count [2];
  logic                  r_head  [2];
  logic                  r_tail  [2];
  logic [DATA_WIDTH-1:0] r_mem   [2][2];

  // Unpack per-client address and write-data slices.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      w_addr[i]  = bus_if.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_wdata[i] = bus_if.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Response FIFO status: head presentation, pop, and read credit.
  // Every slot is either occupied or reserved by the in-flight read, so a
  // read is only granted when count + inflight leaves room, or a pop this
  // cycle frees a slot.
  always_comb begin
    w_pop            = '0;
    w_credit         = '0;
    bus_if.rsp_valid = '0;
    bus_if.rsp_data  = '0;
    if (i_rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        bus_if.rsp_valid[i] = (r_count[i] != 2'd0);
        bus_if.rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[i][r_head[i]];
        w_pop[i]    = (r_count[i] != 2'd0) & bus_if.rsp_ready[i];
        w_credit[i] = ((r_count[i] + {1'b0, r_inflight[i]}) < 2'd2) | w_pop[i];
      end
    end
  end

  // Write/read arbitration with round-robin tie-break and collision veto.
  always_comb begin
    w_wreq    = '0;
    w_rreq    = '0;
    w_wgnt    = '0;
    w_rgnt    = '0;
    w_wsel    = 1'b0;
    w_rsel    = 1'b0;
    w_wany    = 1'b0;
    w_rany    = 1'b0;
    w_collide = 1'b0;
    if (i_rst_n) begin
      w_wreq = bus_if.req_valid & bus_if.req_we;
      w_rreq = bus_if.req_valid & ~bus_if.req_we & w_credit;
      w_wany = |w_wreq;
      w_rany = |w_rreq;
      // With a single requester the requester wins; with two, the pointer.
      w_wsel = (w_wreq == 2'b11) ? r_wptr : w_wreq[1];
      w_rsel = (w_rreq == 2'b11) ? r_rptr : w_rreq[1];
      // A read to the address being written this cycle waits a cycle so it
      // observes the new data.
      w_collide = w_wany & w_rany & (w_addr[w_wsel] == w_addr[w_rsel]);
      if (w_wany) begin
        w_wgnt[w_wsel] = 1'b1;
      end
      if (w_rany && !w_collide) begin
        w_rgnt[w_rsel] = 1'b1;
      end
    end
  end

  assign bus_if.req_ready = w_wgnt | w_rgnt;

  // RAM port drive; unused address/data are held at zero.
  always_comb begin
    o_ram_we      = |w_wgnt;
    o_ram_re      = |w_rgnt;
    o_ram_wr_addr = '0;
    o_ram_di      = '0;
    o_ram_rd_addr = '0;
    if (|w_wgnt) begin
      o_ram_wr_addr = w_addr[w_wsel];
      o_ram_di      = w_wdata[w_wsel];
    end
    if (|w_rgnt) begin
      o_ram_rd_addr = w_addr[w_rsel];
    end
  end

  // Pointers, in-flight flags and FIFO bookkeeping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_inflight <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_count[i] <= 2'd0;
        r_head[i]  <= 1'b0;
        r_tail[i]  <= 1'b0;
      end
    end else begin
      if (|w_wgnt) begin
        r_wptr <= ~w_wsel;
      end
      if (|w_rgnt) begin
        r_rptr <= ~w_rsel;
      end
      r_inflight <= w_rgnt;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_inflight[i]) begin
          r_tail[i] <= ~r_tail[i];
        end
        if (w_pop[i]) begin
          r_head[i] <= ~r_head[i];
        end
        r_count[i] <= r_count[i] + {1'b0, r_inflight[i]} - {1'b0, w_pop[i]};
      end
    end
  end

  // FIFO storage: capture RAM read data the cycle after the grant.
  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (i_rst_n && r_inflight[i]) begin
        r_mem[i][r_tail[i]] <= i_ram_do;
      end
    end
  end

endmodule

// File: doc/bram_dual_arbiter.md
BRAM_DUAL_ARBITER -- requirements
Module: bram_dual_arbiter

Interface
REQ-001 Parameters: ADDR_WIDTH, default 10, RAM address width; DATA_WIDTH, default 32, RAM data width.
REQ-002 CLK  in  1  clock; all state updates on rising edge.
REQ-003 RST_N  in  1  synchronous active-low reset.
REQ-004 REQ_VALID  in  2  per-client request valid; bit i = client i.
REQ-005 REQ_READY  out  2  per-client request accepted this cycle.
REQ-006 REQ_WE  in  2  per-client request type; 1 = write, 0 = read.
REQ-007 REQ_ADDR  in  2*ADDR_WIDTH  per-client address; slice i = client i.
REQ-008 REQ_DATA  in  2*DATA_WIDTH  per-client write data.
REQ-009 RSP_VALID  out  2  per-client read response valid.
REQ-010 RSP_READY  in  2  per-client read response consumed.
REQ-011 RSP_DATA  out  2*DATA_WIDTH  per-client read data.
REQ-012 RAM_WE, RAM_RE  out  1 each  write/read enable to the dual-port RAM.
REQ-013 RAM_WR_ADDR, RAM_RD_ADDR  out  ADDR_WIDTH each  RAM write/read address.
REQ-014 RAM_DI  out  DATA_WIDTH  RAM write data; RAM_DO  in  DATA_WIDTH  RAM read data, registered, valid the cycle after RAM_RE.

Function
REQ-015 Request handshake: accepted on a cycle with REQ_VALID[i] & REQ_READY[i]; REQ_READY SHALL be combinational from current inputs and state.
REQ-016 Per cycle, at most one write grant and one read grant; one write and one read from different clients may proceed together.
REQ-017 Write arbitration: round-robin pointer WPTR (1 bit); if both clients request writes, the client at WPTR wins; after any write grant WPTR = other client.
REQ-018 Read arbitration: independent round-robin pointer RPTR with the same rule, among read requesters with credit (REQ-021).
REQ-019 Collision: if the read winner address equals the write winner address in the same cycle, the read SHALL NOT be granted (REQ_READY low, RPTR unchanged); the write proceeds; the read retries next cycle and returns the new data.
REQ-020 RAM drive: RAM_WE = write granted, RAM_WR_ADDR/RAM_DI = winner's slices; RAM_RE = read granted, RAM_RD_ADDR = winner's slice; unused address/data outputs SHALL be 0; RAM_WE & RAM_RE with equal addresses SHALL never occur.
REQ-021 Per client: 2-entry response FIFO plus 1-bit in-flight flag. Read credit exists when fifo_count + inflight < 2, or when a response is dequeued the same cycle.
REQ-022 A granted read sets that client's inflight; next cycle RAM_DO is pushed into that client's FIFO and inflight clears, unless a new read for that client is granted the same cycle.
REQ-023 Read latency: RSP_VALID rises 2 cycles after request acceptance when the FIFO is empty; sustained 1 read/cycle/client when RSP_READY is held high.
REQ-024 RSP_VALID[i] = FIFO i non-empty; RSP_DATA slice = FIFO head; pop on RSP_VALID & RSP_READY; responses SHALL be in request order per client.
REQ-025 Writes produce no response; a write is complete at acceptance.
REQ-026 Simultaneous push and pop on a full or empty FIFO SHALL be handled without loss or duplication.

Reset
REQ-027 While RST_N = 0: REQ_READY = 0, RAM_WE = 0, RAM_RE = 0, RAM address/data outputs = 0, RSP_VALID = 0.
REQ-028 On reset: FIFOs empty, inflight cleared, WPTR = RPTR = 0. A read in flight at reset is discarded, and its RAM_DO is never pushed.
REQ-029 First grants are possible on the cycle RST_N is first sampled high.

Verification
REQ-030 Client 0 writes 0xDEADBEEF to address 5, then reads address 5 -> RSP_VALID[0] rises 2 cycles after read acceptance with data 0xDEADBEEF.
REQ-031 Both clients write every cycle for 4 cycles -> grants alternate 0,1,0,1; RAM_WE high every cycle.
REQ-032 Same cycle: client 0 writes 0x1234 to address 7, client 1 reads address 7 -> cycle 1: write only, REQ_READY[1] = 0; cycle 2: read granted; response = 0x1234; RAM_X never sampled.
REQ-033 Client 1 issues 6 back-to-back reads with RSP_READY[1] = 0 -> exactly 2 accepted, then REQ_READY[1] = 0; raising RSP_READY resumes 1 read/cycle in order.
REQ-034 Reset asserted the cycle after a read grant -> RSP_VALID stays 0 after reset release; the next read returns only its own data.
REQ-035 Random mixed traffic on both clients against a reference memory model -> all read data match the model, per-client order is preserved, and neither client starves for more than 1 cycle while requesting.
